// File: rtl/click_decoder_pkg.sv
// Shared constants for the click decoder: state encoding and the default quiet window,
// kept alongside the debouncer's clock-division settings so both agree on timing.
package click_decoder_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // 100 ms of quiet at a 125 MHz sysclk closes a burst.
    localparam int DEFAULT_WINDOW = 12_500_000;

endpackage

// File: rtl/click_decoder_window_timer.sv
// Quiet-window timer: synchronous clear, counts while enabled, and stops at WINDOW-1
// where it raises a terminal flag. It never wraps.
module window_timer #(
    parameter int WINDOW = 8
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int TMR_W = $clog2(WINDOW);

    logic [TMR_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == TMR_W'(WINDOW - 1));
    assign o_terminal = w_terminal;

    // Clear takes priority so a pulse arriving on the terminal cycle restarts the window.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press pulses into bursts and, after a quiet window, emits one
// classified event (count, overflow, single/double strobes) per burst.
module click_decoder
    import click_decoder_pkg::*;
#(
    parameter int WINDOW     = DEFAULT_WINDOW,
    parameter int MAX_CLICKS = 3
) (
    input  logic                             sysclk,
    input  logic                             rst_n,
    input  logic                             btn_pulse,
    output logic                             busy,
    output logic                             event_valid,
    output logic [$clog2(MAX_CLICKS+1)-1:0] click_count,
    output logic                             overflow,
    output logic                             single_click,
    output logic                             double_click
);

    localparam int CNT_W = $clog2(MAX_CLICKS + 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_event_valid;
    logic [CNT_W-1:0] r_click_count;
    logic             r_overflow;
    logic             r_single_click;
    logic             r_double_click;

    logic w_counting;
    logic w_terminal;
    logic w_timer_clear;
    logic w_expire;

    assign w_counting    = (r_state == ST_COUNTING);
    assign w_timer_clear = btn_pulse || !w_counting;
    assign w_expire      = w_counting && !btn_pulse && w_terminal;

    window_timer #(
        .WINDOW (WINDOW)
    ) u_window_timer (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clear),
        .i_enable   (w_counting),
        .o_terminal (w_terminal)
    );

    // A pulse always beats expiry; the count saturates and remembers it overflowed.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (!w_counting) begin
            if (btn_pulse) begin
                r_state <= ST_COUNTING;
                r_count <= CNT_W'(1);
                r_ovf   <= 1'b0;
            end
        end else if (btn_pulse) begin
            if (r_count == CNT_W'(MAX_CLICKS)) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_terminal) begin
            r_state <= ST_IDLE;
        end
    end

    // Strobes last one cycle; click_count holds until the next event.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_event_valid  <= 1'b0;
            r_click_count  <= '0;
            r_overflow     <= 1'b0;
            r_single_click <= 1'b0;
            r_double_click <= 1'b0;
        end else begin
            r_event_valid  <= w_expire;
            r_overflow     <= w_expire && r_ovf;
            r_single_click <= w_expire && (r_count == CNT_W'(1));
            r_double_click <= w_expire && (r_count == CNT_W'(2));
            if (w_expire) begin
                r_click_count <= r_count;
            end
        end
    end

    assign busy         = w_counting;
    assign event_valid  = r_event_valid;
    assign click_count  = r_click_count;
    assign overflow     = r_overflow;
    assign single_click = r_single_click;
    assign double_click = r_double_click;

endmodule

// File: tb/tb_click_decoder.sv
// Scoreboard bench for click_decoder: a gap-based burst model queues expected events,
// and a monitor on the falling edge pops and compares them as the DUT emits events.
module tb_click_decoder;

    localparam int WINDOW     = 8;
    localparam int MAX_CLICKS = 3;
    localparam int CNT_W      = $clog2(MAX_CLICKS + 1);

    logic             sysclk    = 1'b0;
    logic             rst_n     = 1'b0;
    logic             btn_pulse = 1'b0;
    logic             busy;
    logic             event_valid;
    logic [CNT_W-1:0] click_count;
    logic             overflow;
    logic             single_click;
    logic             double_click;

    typedef struct {
        int cycle;
        int count;
        int ovf;
    } event_t;

    event_t expQ[$];

    int checks    = 0;
    int errors    = 0;
    int cycleNum  = 0;
    int mPulses   = 0;
    int mLast     = 0;
    int lastCount = 0;
    bit mOpen     = 1'b0;
    bit modelBusy = 1'b0;

    click_decoder #(
        .WINDOW     (WINDOW),
        .MAX_CLICKS (MAX_CLICKS)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .btn_pulse    (btn_pulse),
        .busy         (busy),
        .event_valid  (event_valid),
        .click_count  (click_count),
        .overflow     (overflow),
        .single_click (single_click),
        .double_click (double_click)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNum, actual, expected);
        end
    endtask

    // Reference model: a burst closes when WINDOW whole cycles pass with no pulse after
    // the last one; the event then shows in the following cycle.
    always @(posedge sysclk) begin
        cycleNum++;
        if (!rst_n) begin
            mOpen     = 1'b0;
            modelBusy = 1'b0;
        end else begin
            if (btn_pulse) begin
                if (!mOpen) begin
                    mOpen   = 1'b1;
                    mPulses = 1;
                end else begin
                    mPulses++;
                end
                mLast = cycleNum - 1;
            end else if (mOpen && (cycleNum - 1 - mLast) == WINDOW) begin
                expQ.push_back('{cycleNum,
                                 (mPulses > MAX_CLICKS) ? MAX_CLICKS : mPulses,
                                 (mPulses > MAX_CLICKS) ? 1 : 0});
                mOpen = 1'b0;
            end
            modelBusy = mOpen;
        end
    end

    always @(negedge rst_n) begin
        expQ.delete();
        mOpen     = 1'b0;
        modelBusy = 1'b0;
        lastCount = 0;
    end

    always @(negedge sysclk) begin
        if (!rst_n) begin
            checkOutput("resetOutputs",
                        int'({busy, event_valid, overflow, single_click, double_click, click_count}), 0);
        end else begin
            checkOutput("busy", int'(busy), int'(modelBusy));
            if (event_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedEvent", 1, 0);
                end else begin
                    event_t e;
                    e = expQ.pop_front();
                    checkOutput("eventCycle", cycleNum, e.cycle);
                    checkOutput("clickCount", int'(click_count), e.count);
                    checkOutput("overflow", int'(overflow), e.ovf);
                    checkOutput("singleClick", int'(single_click), (e.count == 1) ? 1 : 0);
                    checkOutput("doubleClick", int'(double_click), (e.count == 2) ? 1 : 0);
                    lastCount = e.count;
                end
            end else begin
                checkOutput("idleStrobes", int'({overflow, single_click, double_click}), 0);
                checkOutput("heldCount", int'(click_count), lastCount);
                if (expQ.size() > 0 && expQ[0].cycle <= cycleNum) begin
                    checkOutput("missedEvent", 0, 1);
                    void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] pattern, input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge sysclk);
            #1;
            btn_pulse = pattern[i];
        end
        @(posedge sysclk);
        #1;
        btn_pulse = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    initial begin
        int p;
        int len;
        $display("[TB] start WINDOW=%0d MAX_CLICKS=%0d", WINDOW, MAX_CLICKS);
        repeat (3) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);

        applyStimulus(64'h1, 1);
        idleCycles(WINDOW + 4);
        applyStimulus(64'h21, 6);
        idleCycles(WINDOW + 4);
        applyStimulus(64'h155, 9);
        idleCycles(WINDOW + 4);
        applyStimulus(64'h101, 9);
        idleCycles(WINDOW + 4);
        applyStimulus(64'h201, 10);
        idleCycles(WINDOW + 4);
        applyStimulus(64'hFF, 8);
        idleCycles(WINDOW + 4);

        applyStimulus(64'h9, 5);
        rst_n = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        idleCycles(2 * WINDOW);
        applyStimulus(64'h1, 1);
        idleCycles(WINDOW + 4);

        for (int b = 0; b < 250; b++) begin
            p   = $urandom_range(5, 70);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                @(posedge sysclk);
                #1;
                btn_pulse = ($urandom_range(0, 99) < p);
            end
            @(posedge sysclk);
            #1;
            btn_pulse = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                idleCycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            idleCycles($urandom_range(0, WINDOW + 3));
        end

        idleCycles(3 * WINDOW);
        if (expQ.size() != 0) begin
            checkOutput("drainedQueue", expQ.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
